muldiv_unit: RTL and testbench

Iterative RV64M/RV32M multiply–divide unit for the execute stage. It takes operands after forwarding, runs a shift-add multiply or restoring divide over several cycles, and returns a RISC-V-conformant result through a valid/ready handshake. The pipeline stalls decode/execute while `in_ready` is low and holds the instruction until `out_valid`. Datapath width is a parameter. Word (W-suffix) forms are supported when XLEN=64.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 174 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - operation/result handshake bundle for muldiv_unit
//
// Groups the execute-stage request (in_valid/in_ready, op, word, src1, src2,
// flush) and the result return (out_valid/out_ready, result).
// master: execute stage driving operations and taking results.
// slave : the multiply-divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic            word;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    modport master (
        output in_valid, op, word, src1, src2, flush, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, op, word, src1, src2, flush, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply-divide unit
//
// Shift-add multiply and restoring divide, one bit per cycle, working on
// operand magnitudes with a sign fix-up at the end.
// Ports:
//   clk   - clock
//   reset - asynchronous active-high reset
//   bus   - muldiv_unit_if.slave: in_valid/in_ready, op, word, src1, src2,
//           flush, out_valid/out_ready, result
// Optional feature macro: MULDIV_SPECIAL_BYPASS_EN - divide-by-zero, signed
// overflow and zero-operand multiplies complete on the accept edge.
module muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    // Decode of the offered operation
    logic            accept, is_word, is_div, a_signed, b_signed;
    logic            a_neg, b_neg, neg, special;
    logic [2:0]      op_eff;
    logic [XLEN-1:0] a_val, b_val, a_abs, b_abs, a_mag, b_mag;
    logic [XLEN-1:0] min_mag, special_val;
    logic [CW-1:0]   n_load;

    // Latched operation and datapath
    logic [2:0]        op_r;
    logic              word_r, neg_r, special_r;
    logic [XLEN-1:0]   special_val_r, result_r;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] mcand, acc, acc_step, prod_fix;
    logic [XLEN-1:0]   shreg, divisor, rem;
    logic [XLEN-1:0]   shreg_div, rem_step, quo_fix, rem_fix, raw_val, final_val;
    logic [XLEN:0]     trial, diff;
    logic              q_bit;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.result    = result_r;
    assign accept        = bus.in_valid && (state == IDLE) && !bus.flush;

    always_comb begin
        is_word = (XLEN == 64) && bus.word;
        op_eff  = bus.op;
        // Word forms of MULH/MULHSU/MULHU do not exist; they run as MULW
        if (is_word && (bus.op inside {3'd1, 3'd2, 3'd3}))
            op_eff = 3'd0;
        is_div   = op_eff[2];
        a_signed = op_eff inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6};
        b_signed = op_eff inside {3'd0, 3'd1, 3'd4, 3'd6};
        a_val    = is_word ? XLEN'($signed(bus.src1[31:0])) : bus.src1;
        b_val    = is_word ? XLEN'($signed(bus.src2[31:0])) : bus.src2;
        a_neg    = a_signed && a_val[XLEN-1];
        b_neg    = b_signed && b_val[XLEN-1];
        a_abs    = a_neg ? -a_val : a_val;
        b_abs    = b_neg ? -b_val : b_val;
        a_mag    = is_word ? XLEN'(a_abs[31:0]) : a_abs;
        b_mag    = is_word ? XLEN'(b_abs[31:0]) : b_abs;
        // Remainder takes the dividend's sign, everything else the XOR
        neg      = (op_eff[2] && op_eff[1]) ? a_neg : (a_neg ^ b_neg);
        min_mag  = is_word ? XLEN'(64'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        n_load   = is_word ? CW'(32) : CW'(XLEN);

        special     = 1'b0;
        special_val = '0;
        if (is_div) begin
            if (b_mag == '0) begin
                special     = 1'b1;
                special_val = op_eff[1] ? a_val : '1;
            end else if (a_neg && b_neg && (a_mag == min_mag) && (b_mag == XLEN'(1))) begin
                special     = 1'b1;
                special_val = op_eff[1] ? '0 : a_val;
            end
        end else if ((a_mag == '0) || (b_mag == '0)) begin
            special = 1'b1;
        end
    end

    // One iteration of both algorithms; the result is formed from the
    // post-iteration values so it can be registered on the final edge.
    always_comb begin
        acc_step  = shreg[0] ? (acc + mcand) : acc;
        trial     = {rem, shreg[XLEN-1]};
        diff      = trial - {1'b0, divisor};
        q_bit     = ~diff[XLEN];
        rem_step  = q_bit ? diff[XLEN-1:0] : trial[XLEN-1:0];
        shreg_div = {shreg[XLEN-2:0], q_bit};
        prod_fix  = neg_r ? -acc_step : acc_step;
        quo_fix   = neg_r ? -shreg_div : shreg_div;
        rem_fix   = neg_r ? -rem_step : rem_step;
        case (op_r)
            3'd0:                 raw_val = prod_fix[XLEN-1:0];
            3'd1, 3'd2, 3'd3:     raw_val = prod_fix[2*XLEN-1:XLEN];
            3'd4, 3'd5:           raw_val = quo_fix;
            default:              raw_val = rem_fix;
        endcase
        final_val = word_r ? XLEN'($signed(raw_val[31:0])) : raw_val;
        if (special_r)
            final_val = special_val_r;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_SPECIAL_BYPASS_EN
                    state_next = special ? DONE : BUSY;
`else
                    state_next = BUSY;
`endif
                end
            end
            BUSY:    if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (bus.flush)
            state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            result_r      <= '0;
            op_r          <= '0;
            word_r        <= 1'b0;
            neg_r         <= 1'b0;
            special_r     <= 1'b0;
            special_val_r <= '0;
            mcand         <= '0;
            acc           <= '0;
            shreg         <= '0;
            divisor       <= '0;
            rem           <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_r          <= op_eff;
                word_r        <= is_word;
                neg_r         <= neg;
                special_r     <= special;
                special_val_r <= special_val;
                cnt           <= n_load;
                mcand         <= {{XLEN{1'b0}}, a_mag};
                acc           <= '0;
                rem           <= '0;
                divisor       <= b_mag;
                // Word dividends sit in the top half so N=32 shifts consume them
                shreg         <= is_div ? (is_word ? (a_mag << 32) : a_mag) : b_mag;
`ifdef MULDIV_SPECIAL_BYPASS_EN
                if (special)
                    result_r <= special_val;
`endif
            end else if ((state == BUSY) && !bus.flush) begin
                cnt   <= cnt - CW'(1);
                mcand <= mcand << 1;
                acc   <= acc_step;
                shreg <= op_r[2] ? shreg_div : (shreg >> 1);
                rem   <= rem_step;
                if (cnt == CW'(1))
                    result_r <= final_val;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit (XLEN=64)
module tb_muldiv_unit;
`ifdef MULDIV_SPECIAL_BYPASS_EN
    localparam int SPEC_LAT = 1;
`else
    localparam int SPEC_LAT = 65;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cycle_no = 0;
    int   vectors = 0;
    int   miscompares = 0;

    muldiv_unit_if #(.XLEN(64)) bus ();

    muldiv_unit #(.XLEN(64)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle_no <= cycle_no + 1;

    typedef struct {
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        int          lat;
    } vec_t;

    // Reference: RISC-V M-extension semantics in plain arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         ua32, ub32, r32;
        logic signed [63:0]  sa, sb;
        logic [63:0]         r;
        sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
        sa = a; sb = b;
        r = '0; r32 = '0;
        if (w) begin
            case (o)
                3'd4: begin
                    if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                    else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                    else r32 = sa32 / sb32;
                end
                3'd5: begin
                    if (ub32 == 0) r32 = 32'hFFFF_FFFF;
                    else r32 = ua32 / ub32;
                end
                3'd6: begin
                    if (ub32 == 0) r32 = ua32;
                    else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = 32'd0;
                    else r32 = sa32 % sb32;
                end
                3'd7: begin
                    if (ub32 == 0) r32 = ua32;
                    else r32 = ua32 % ub32;
                end
                default: r32 = ua32 * ub32;
            endcase
            r = {{32{r32[31]}}, r32};
        end else begin
            case (o)
                3'd0: r = a * b;
                3'd1: begin
                    sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
                    r = sp[127:64];
                end
                3'd2: begin
                    sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
                    r = sp[127:64];
                end
                3'd3: begin
                    up = {64'd0, a} * {64'd0, b};
                    r = up[127:64];
                end
                3'd4: begin
                    if (b == 0) r = '1;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
                    else r = sa / sb;
                end
                3'd5: begin
                    if (b == 0) r = '1;
                    else r = a / b;
                end
                3'd6: begin
                    if (b == 0) r = a;
                    else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
                    else r = sa % sb;
                end
                default: begin
                    if (b == 0) r = a;
                    else r = a % b;
                end
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] o, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
`ifdef MULDIV_SPECIAL_BYPASS_EN
        logic az, bz, ovf;
        az  = w ? (a[31:0] == 0) : (a == 0);
        bz  = w ? (b[31:0] == 0) : (b == 0);
        ovf = w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                : (a == 64'h8000_0000_0000_0000 && b == '1);
        if (o[2] && bz) return 1;
        if ((o == 3'd4 || o == 3'd6) && ovf) return 1;
        if (!o[2] && (az || bz)) return 1;
`endif
        return (w ? 32 : 64) + 1;
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] v;
        v = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = 64'h8000_0000_0000_0000;
            3: v = {v[63:32], 32'h8000_0000};
            4: v = 64'($urandom_range(0, 15));
            5: v = {v[63:32], 32'hFFFF_FFFF};
            default: ;
        endcase
        return v;
    endfunction

    // Offers one operation (called one time unit after a rising edge) and
    // takes its result. lat is the cycle out_valid is first seen, -1 on timeout.
    task automatic issue(input logic [2:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res,
                         output int lat, output int t_acc);
        int guard;
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        bus.in_valid = 1'b1; bus.op = o; bus.word = w; bus.src1 = a; bus.src2 = b;
        t_acc = cycle_no;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = bus.result;
        if (!bus.out_valid) begin
            lat = -1;
        end else begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
        vectors++;
        if (bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        end
        vectors++;
        if (bus.result !== 64'd0) begin
            miscompares++; $display("FAIL reset_result: got %h expected 0", bus.result);
        end
    endtask

    task automatic test_directed();
        vec_t        v [9];
        logic [63:0] res;
        int          lat, t;
        v[0] = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        v[1] = '{3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        v[2] = '{3'd1, 1'b0, '1, '1, 64'd0, 65};
        v[3] = '{3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33};
        v[4] = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        v[5] = '{3'd4, 1'b0, 64'd5, 64'd0, '1, SPEC_LAT};
        v[6] = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, SPEC_LAT};
        v[7] = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, SPEC_LAT};
        v[8] = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, SPEC_LAT};
        for (int i = 0; i < 9; i++) begin
            issue(v[i].op, v[i].word, v[i].a, v[i].b, res, lat, t);
            vectors++;
            if (res !== v[i].exp) begin
                miscompares++;
                $display("FAIL directed[%0d]_result: got %h expected %h", i, res, v[i].exp);
            end
            vectors++;
            if (lat !== v[i].lat) begin
                miscompares++;
                $display("FAIL directed[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic        w;
        logic [63:0] a, b, res, exp;
        int          lat, t, el;
        for (int i = 0; i < 50; i++) begin
            o = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1));
            a = rand_operand();
            b = rand_operand();
            exp = model(o, w, a, b);
            el  = exp_lat(o, w, a, b);
            issue(o, w, a, b, res, lat, t);
            vectors++;
            if (res !== exp) begin
                miscompares++;
                $display("FAIL random[%0d]_result op=%0d w=%b a=%h b=%h: got %h expected %h",
                         i, o, w, a, b, res, exp);
            end
            vectors++;
            if (lat !== el) begin
                miscompares++;
                $display("FAIL random[%0d]_latency: got %0d expected %0d", i, lat, el);
            end
        end
    endtask

    task automatic test_flush();
        logic        seen;
        logic [63:0] a, b, res;
        int          lat, t, guard;
        // Flush in cycle 10 of a DIV
        seen = 1'b0;
        bus.in_valid = 1'b1; bus.op = 3'd4; bus.word = 1'b0;
        bus.src1 = 64'd1000; bus.src2 = 64'd7;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int c = 1; c < 10; c++) begin
            if (bus.out_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        if (bus.out_valid) seen = 1'b1;
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_busy_in_ready: got %b expected 1", bus.in_ready);
        end
        vectors++;
        if (seen !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++; $display("FAIL flush_busy_out_valid: got %b expected 0", seen | bus.out_valid);
        end
        a = {$urandom, $urandom} | 64'd1;
        b = {$urandom, $urandom} | 64'd1;
        issue(3'd0, 1'b0, a, b, res, lat, t);
        vectors++;
        if (res !== model(3'd0, 1'b0, a, b) || lat !== 65) begin
            miscompares++;
            $display("FAIL flush_next_mul: got %h/%0d expected %h/65", res, lat, model(3'd0, 1'b0, a, b));
        end
        // Flush wins over a simultaneous accept
        bus.in_valid = 1'b1; bus.flush = 1'b1; bus.op = 3'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++; $display("FAIL flush_vs_accept: got in_ready %b expected 1", bus.in_ready);
        end
        // Flush in DONE drops the result without out_ready
        bus.in_valid = 1'b1; bus.op = 3'd5; bus.word = 1'b1; bus.src1 = 64'd99; bus.src2 = 64'd4;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        vectors++;
        if (guard >= 200 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_done: got out_valid %b in_ready %b (guard %0d) expected 0/1",
                     bus.out_valid, bus.in_ready, guard);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, r0, exp;
        int          guard;
        a = {$urandom, $urandom};
        b = 64'($urandom_range(1, 1000));
        exp = model(3'd7, 1'b0, a, b);
        bus.in_valid = 1'b1; bus.op = 3'd7; bus.word = 1'b0; bus.src1 = a; bus.src2 = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 200) begin
            @(posedge clk); #1; guard++;
        end
        r0 = bus.result;
        vectors++;
        if (r0 !== exp || guard >= 200) begin
            miscompares++; $display("FAIL bp_result: got %h expected %h", r0, exp);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            vectors++;
            if (bus.result !== exp || bus.out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got %h valid %b expected %h valid 1",
                         c, bus.result, bus.out_valid, exp);
            end
            vectors++;
            if (bus.in_ready !== 1'b0) begin
                miscompares++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", c, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got in_ready %b out_valid %b expected 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] a, b, res;
        int          lat, t1, t2;
        a = {$urandom, $urandom} | 64'd1;
        b = {$urandom, $urandom} | 64'd1;
        issue(3'd3, 1'b0, a, b, res, lat, t1);
        issue(3'd0, 1'b0, b, a, res, lat, t2);
        vectors++;
        if (t2 - t1 !== 66 || res !== model(3'd0, 1'b0, b, a)) begin
            miscompares++;
            $display("FAIL b2b_full: got period %0d result %h expected 66 %h", t2 - t1, res, model(3'd0, 1'b0, b, a));
        end
        issue(3'd5, 1'b1, a, b, res, lat, t1);
        issue(3'd7, 1'b1, a, b, res, lat, t2);
        vectors++;
        if (t2 - t1 !== 34 || res !== model(3'd7, 1'b1, a, b)) begin
            miscompares++;
            $display("FAIL b2b_word: got period %0d result %h expected 34 %h", t2 - t1, res, model(3'd7, 1'b1, a, b));
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [63:0] res, a, b;
        int          lat, t;
        bus.in_valid = 1'b1; bus.op = 3'd1; bus.word = 1'b0;
        bus.src1 = 64'h1234_5678_9ABC_DEF0; bus.src2 = 64'h0FED_CBA9_8765_4321;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got in_ready %b out_valid %b expected 1/0", bus.in_ready, bus.out_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_mid_busy: got in_ready %b out_valid %b result %h expected 1/0/0",
                     bus.in_ready, bus.out_valid, bus.result);
        end
        a = {$urandom, $urandom};
        b = 64'($urandom_range(1, 50000));
        issue(3'd4, 1'b0, a, b, res, lat, t);
        vectors++;
        if (res !== model(3'd4, 1'b0, a, b) || lat !== 65) begin
            miscompares++;
            $display("FAIL reset_recover: got %h/%0d expected %h/65", res, lat, model(3'd4, 1'b0, a, b));
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.op = 3'd0; bus.word = 1'b0;
        bus.src1 = '0; bus.src2 = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout: got no completion expected finish before time limit");
        $fatal(1, "simulation time limit reached");
    end
endmodule
